// File: rtl/spi_master_core.sv
// SPI mode-0 master shift engine driven by a prescaler half-period tick.
// Optional build macro SPI_LSB_FIRST_EN switches tx and rx bit order to LSB first.
module spi_master_core #(
  parameter int DATA_W         = 8,
  parameter int CS_SETUP_TICKS = 1,
  parameter int CS_HOLD_TICKS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int BIT_CNT_W  = $clog2(DATA_W + 1);
  localparam int TICK_MAX   = (CS_SETUP_TICKS > CS_HOLD_TICKS) ? CS_SETUP_TICKS : CS_HOLD_TICKS;
  localparam int TICK_CNT_W = (TICK_MAX > 1) ? $clog2(TICK_MAX + 1) : 1;

  localparam logic [BIT_CNT_W-1:0]  BIT_LAST   = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_ONE    = BIT_CNT_W'(1);
  localparam logic [TICK_CNT_W-1:0] SETUP_LAST = TICK_CNT_W'(CS_SETUP_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] HOLD_LAST  = TICK_CNT_W'(CS_HOLD_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] TICK_ONE   = TICK_CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]     rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]     rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  done_q, done_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  // Bit that goes on the wire next from a tx word.
  function automatic logic tx_head(input logic [DATA_W-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

  // Drop the bit already presented so tx_head sees the following one.
  function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    return {1'b0, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], b};
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    done_d     = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    tick_cnt_d = tick_cnt_q;

    unique case (state_q)
      IDLE: begin
        // tick is deliberately not consulted here, even alongside start.
        if (start) begin
          state_d    = SETUP;
          cs_n_d     = 1'b0;
          mosi_d     = tx_head(tx_data);
          tx_sr_d    = tx_advance(tx_data);
          rx_sr_d    = '0;
          bit_cnt_d  = '0;
          tick_cnt_d = '0;
        end
      end

      SETUP: begin
        if (tick) begin
          if (tick_cnt_q == SETUP_LAST) begin
            state_d    = XFER;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end
      end

      XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_sr_d = rx_shift(rx_sr_q, miso);
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
            // On the final falling edge mosi keeps the last bit through HOLD.
            if (bit_cnt_q == BIT_LAST) begin
              state_d    = HOLD;
              tick_cnt_d = '0;
            end else begin
              mosi_d  = tx_head(tx_sr_q);
              tx_sr_d = tx_advance(tx_sr_q);
            end
          end
        end
      end

      HOLD: begin
        if (tick) begin
          if (tick_cnt_q == HOLD_LAST) begin
            state_d    = IDLE;
            cs_n_d     = 1'b1;
            mosi_d     = 1'b0;
            done_d     = 1'b1;
            rx_data_d  = rx_sr_q;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
      bit_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
      bit_cnt_q  <= bit_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Scoreboard bench for spi_master_core; tick pulses once every 4 clk.
module tb_spi_master_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  logic loop_en  = 1'b1;
  logic miso_fix = 1'b0;
  logic tick_en  = 1'b1;
  int   div_cnt  = 0;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  int         rise_cnt;
  int         done_cnt;
  int         cs_ticks;
  int         mosi_hi;
  logic [7:0] mosi_word;
  logic       mon_first;
  logic       sclk_prev = 1'b0;
  logic       cs_n_prev = 1'b1;

  assign miso = loop_en ? mosi : miso_fix;

  spi_master_core #(.DATA_W(8), .CS_SETUP_TICKS(1), .CS_HOLD_TICKS(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        div_cnt = (div_cnt + 1) % 4;
        tick = (div_cnt == 0);
      end else begin
        tick = 1'b0;
      end
    end
  end

  // Wire-level monitor: values just after each rising clk edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sclk && !sclk_prev) begin
        rise_cnt++;
`ifdef SPI_LSB_FIRST_EN
        mosi_word = {mosi, mosi_word[7:1]};
`else
        mosi_word = {mosi_word[6:0], mosi};
`endif
        if (rise_cnt == 1) mon_first = mosi;
      end
      if (tick && !cs_n_prev) cs_ticks++;
      if (done) done_cnt++;
      if (mosi) mosi_hi++;
      sclk_prev = sclk;
      cs_n_prev = cs_n;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rise_cnt  = 0;
    done_cnt  = 0;
    cs_ticks  = 0;
    mosi_hi   = 0;
    mosi_word = '0;
    mon_first = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] w, input bit push, input logic [7:0] exp_rx);
    @(negedge clk);
    tx_data = w;
    start   = 1'b1;
    if (push) exp_q.push_back(exp_rx);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rises(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      if (rise_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx got %h want 00", rx_data); end
    n_cmp++; if (sclk !== 1'b0)    begin n_err++; $display("FAIL reset_sclk got %b want 0", sclk); end
    n_cmp++; if (mosi !== 1'b0)    begin n_err++; $display("FAIL reset_mosi got %b want 0", mosi); end
    n_cmp++; if (cs_n !== 1'b1)    begin n_err++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback(input logic [7:0] w);
    bit ok;
    logic [7:0] exp;
    logic exp_first;
`ifdef SPI_LSB_FIRST_EN
    exp_first = w[0];
`else
    exp_first = w[7];
`endif
    loop_en = 1'b1;
    clear_mon();
    start_xfer(w, 1'b1, w);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL loop_%h_done got timeout want done", w); end
    n_cmp++; if (exp_q.size() != 1) begin n_err++; $display("FAIL loop_%h_sb got %0d entries want 1", w, exp_q.size()); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++; if (rx_data !== exp) begin n_err++; $display("FAIL loop_%h_rx got %h want %h", w, rx_data, exp); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL loop_%h_busy_at_done got %b want 0", w, busy); end
    @(posedge clk); #2;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL loop_%h_done_width got %b want 0", w, done); end
    n_cmp++; if (mosi_word !== w) begin n_err++; $display("FAIL loop_%h_mosi got %h want %h", w, mosi_word, w); end
    n_cmp++; if (mon_first !== exp_first) begin n_err++; $display("FAIL loop_%h_first_bit got %b want %b", w, mon_first, exp_first); end
    n_cmp++; if (rise_cnt != 8) begin n_err++; $display("FAIL loop_%h_rises got %0d want 8", w, rise_cnt); end
    n_cmp++; if (cs_ticks != 18) begin n_err++; $display("FAIL loop_%h_cs_ticks got %0d want 18", w, cs_ticks); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL loop_%h_done_cnt got %0d want 1", w, done_cnt); end
  endtask

  task automatic test_miso_high();
    bit ok;
    logic [7:0] exp;
    loop_en  = 1'b0;
    miso_fix = 1'b1;
    clear_mon();
    start_xfer(8'h00, 1'b1, 8'hFF);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL miso1_done got timeout want done"); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++; if (rx_data !== exp) begin n_err++; $display("FAIL miso1_rx got %h want %h", rx_data, exp); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL miso1_busy_at_done got %b want 0", busy); end
    n_cmp++; if (mosi_hi != 0) begin n_err++; $display("FAIL miso1_mosi_high_cycles got %0d want 0", mosi_hi); end
    loop_en  = 1'b1;
    miso_fix = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    bit ok;
    logic [7:0] exp;
    loop_en = 1'b1;
    clear_mon();
    start_xfer(8'h3C, 1'b1, 8'h3C);
    wait_rises(3, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL busy_start_rises got timeout want 3 rises"); end
    start_xfer(8'hC3, 1'b0, 8'h00);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL busy_start_done got timeout want done"); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++; if (rx_data !== exp) begin n_err++; $display("FAIL busy_start_rx got %h want %h", rx_data, exp); end
    repeat (40) @(negedge clk);
    n_cmp++; if (mosi_word !== 8'h3C) begin n_err++; $display("FAIL busy_start_mosi got %h want 3c", mosi_word); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL busy_start_done_cnt got %0d want 1", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_queued got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    loop_en = 1'b1;
    clear_mon();
    start_xfer(8'h5A, 1'b0, 8'h00);
    wait_rises(3, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL abort_rises got timeout want 3 rises"); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    n_cmp++; if (cs_n !== 1'b1)    begin n_err++; $display("FAIL abort_cs_n got %b want 1", cs_n); end
    n_cmp++; if (sclk !== 1'b0)    begin n_err++; $display("FAIL abort_sclk got %b want 0", sclk); end
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL abort_done got %b want 0", done); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL abort_rx got %h want 00", rx_data); end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL abort_done_cnt got %0d want 0", done_cnt); end
    test_loopback(8'h5A);
  endtask

  task automatic test_tick_stall();
    bit ok;
    bit frozen;
    logic [7:0] exp;
    logic s_sclk, s_mosi, s_cs_n, s_busy;
    loop_en = 1'b1;
    clear_mon();
    start_xfer(8'h96, 1'b1, 8'h96);
    wait_rises(5, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_rises got timeout want 5 rises"); end
    @(negedge clk);
    tick_en = 1'b0;
    @(posedge clk); #2;
    s_sclk = sclk; s_mosi = mosi; s_cs_n = cs_n; s_busy = busy;
    frozen = 1'b1;
    repeat (50) begin
      @(posedge clk); #2;
      if (sclk !== s_sclk || mosi !== s_mosi || cs_n !== s_cs_n || busy !== s_busy) frozen = 1'b0;
    end
    n_cmp++; if (!frozen) begin n_err++; $display("FAIL stall_frozen got outputs changing want held"); end
    n_cmp++; if (s_busy !== 1'b1) begin n_err++; $display("FAIL stall_busy got %b want 1", s_busy); end
    @(negedge clk);
    tick_en = 1'b1;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_done got timeout want done"); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++; if (rx_data !== exp) begin n_err++; $display("FAIL stall_rx got %h want %h", rx_data, exp); end
    repeat (4) @(negedge clk);
    n_cmp++; if (mosi_word !== 8'h96) begin n_err++; $display("FAIL stall_mosi got %h want 96", mosi_word); end
    n_cmp++; if (rise_cnt != 8) begin n_err++; $display("FAIL stall_rises_total got %0d want 8", rise_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tx_data = '0;
    clear_mon();
    test_reset();
    test_loopback(8'hA5);
    test_miso_high();
    test_start_while_busy();
    test_reset_abort();
    test_tick_stall();
`ifdef SPI_LSB_FIRST_EN
    test_loopback(8'h01);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
